// File: rtl/serial_link_pkg.sv
// -----------------------------------------------------------------------------
// serial_link_pkg
// Shared definitions for the serial-link bring-up controller:
//   - link_state_t / ST_* : bring-up sequencer state encoding
//   - apb_phase_t / APB_* : APB transfer engine phase encoding
//   - CMD_*               : values written to the CTRL register
//   - state_is_busy()     : states in which a bring-up sequence is running
// -----------------------------------------------------------------------------
package serial_link_pkg;

  // Bring-up sequencer states (fixed encoding kept for register-dump tooling).
  typedef logic [3:0] link_state_t;
  localparam link_state_t ST_IDLE     = 4'd0;
  localparam link_state_t ST_WR_UNRST = 4'd1;
  localparam link_state_t ST_WR_RST   = 4'd2;
  localparam link_state_t ST_WR_CLKEN = 4'd3;
  localparam link_state_t ST_SETTLE   = 4'd4;
  localparam link_state_t ST_WR_DEISO = 4'd5;
  localparam link_state_t ST_POLL     = 4'd6;
  localparam link_state_t ST_DONE     = 4'd7;
  localparam link_state_t ST_ERROR    = 4'd8;

  // APB engine phases.
  typedef logic [1:0] apb_phase_t;
  localparam apb_phase_t APB_IDLE   = 2'd0;
  localparam apb_phase_t APB_SETUP  = 2'd1;
  localparam apb_phase_t APB_ACCESS = 2'd2;

  // CTRL register command words, in the order they are issued.
  localparam logic [31:0] CMD_UNRST = 32'h0000_0300;
  localparam logic [31:0] CMD_RST   = 32'h0000_0302;
  localparam logic [31:0] CMD_CLKEN = 32'h0000_0303;
  localparam logic [31:0] CMD_DEISO = 32'h0000_0003;

  // A sequence is running in every state except the three resting states.
  function automatic logic state_is_busy(input link_state_t s);
    return !(s == ST_IDLE || s == ST_DONE || s == ST_ERROR);
  endfunction

endpackage

// File: rtl/serial_link_apb_mst.sv
// -----------------------------------------------------------------------------
// serial_link_apb_mst
// APB single-transfer engine. A request is accepted (gnt) only while idle; the
// engine then runs one SETUP cycle and as many ACCESS cycles as the slave
// needs. done/err pulse in the completing ACCESS cycle. All APB outputs are
// registered and held stable for the whole transfer.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset (aborts transfer)
//   req, wr, addr,      transfer request and its attributes, sampled on gnt
//   wdata, strb
//   gnt                 request accepted this cycle
//   done, err           transfer completed OK / completed with pslverr
//   paddr..pstrb        APB master outputs
//   pready, pslverr     APB slave responses
// -----------------------------------------------------------------------------
module serial_link_apb_mst
  import serial_link_pkg::*;
#(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic                   wr,
  input  logic [AddrWidth-1:0]   addr,
  input  logic [DataWidth-1:0]   wdata,
  input  logic [DataWidth/8-1:0] strb,
  output logic                   gnt,
  output logic                   done,
  output logic                   err,
  output logic [AddrWidth-1:0]   paddr,
  output logic                   psel,
  output logic                   penable,
  output logic                   pwrite,
  output logic [DataWidth-1:0]   pwdata,
  output logic [DataWidth/8-1:0] pstrb,
  input  logic                   pready,
  input  logic                   pslverr
);

  apb_phase_t phase_q;

  assign gnt  = (phase_q == APB_IDLE) && req;
  assign done = (phase_q == APB_ACCESS) && pready && !pslverr;
  assign err  = (phase_q == APB_ACCESS) && pready &&  pslverr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= APB_IDLE;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
      pstrb   <= '0;
    end else begin
      case (phase_q)
        APB_IDLE: begin
          if (req) begin
            phase_q <= APB_SETUP;
            psel    <= 1'b1;
            penable <= 1'b0;
            pwrite  <= wr;
            paddr   <= addr;
            pwdata  <= wdata;
            pstrb   <= strb;
          end
        end
        APB_SETUP: begin
          phase_q <= APB_ACCESS;
          penable <= 1'b1;
        end
        APB_ACCESS: begin
          // Address/data stay untouched until the next grant.
          if (pready) begin
            phase_q <= APB_IDLE;
            psel    <= 1'b0;
            penable <= 1'b0;
          end
        end
        default: begin
          phase_q <= APB_IDLE;
          psel    <= 1'b0;
          penable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/serial_link_bringup_ctrl.sv
// -----------------------------------------------------------------------------
// serial_link_bringup_ctrl
// Brings a serial link out of reset over APB: writes 300/302/303 to CTRL,
// waits WaitCycles for the clock to settle, writes 03 to de-isolate, then
// polls ISOLATED until bits [1:0] read 0.
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   start_i              bring-up request (accepted in IDLE/DONE/ERROR)
//   busy_o               sequence running
//   done_o, error_o      link ready / sequence failed (held until next start)
//   paddr_o..pstrb_o     APB master request outputs
//   prdata_i, pready_i,  APB slave responses
//   pslverr_i
//
// Build option:
//   SERIAL_LINK_BRINGUP_TIMEOUT_EN  when defined, give up with error_o after
//                                   MaxPolls ISOLATED reads that never clear.
// -----------------------------------------------------------------------------
module serial_link_bringup_ctrl
  import serial_link_pkg::*;
#(
  parameter int          AddrWidth         = 32,
  parameter int          DataWidth         = 32,
  parameter logic [31:0] CtrlRegOffset     = 32'h0,
  parameter logic [31:0] IsolatedRegOffset = 32'h4,
  parameter int          WaitCycles        = 50,
  parameter int          MaxPolls          = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic [AddrWidth-1:0]   paddr_o,
  output logic                   psel_o,
  output logic                   penable_o,
  output logic                   pwrite_o,
  output logic [DataWidth-1:0]   pwdata_o,
  output logic [DataWidth/8-1:0] pstrb_o,
  input  logic [DataWidth-1:0]   prdata_i,
  input  logic                   pready_i,
  input  logic                   pslverr_i
);

  localparam int                SettleW    = $clog2(WaitCycles + 1);
  localparam logic [SettleW-1:0] SettleLast = SettleW'(WaitCycles - 1);

  link_state_t                state_q;
  logic [SettleW-1:0]         settle_cnt_q;
  logic                       in_flight_q;
  logic                       poll_limit_hit;
  logic                       iso_set;

  logic                       xfer_req;
  logic                       xfer_wr;
  logic [AddrWidth-1:0]       xfer_addr;
  logic [DataWidth-1:0]       xfer_wdata;
  logic [DataWidth/8-1:0]     xfer_strb;
  logic                       xfer_gnt;
  logic                       xfer_done;
  logic                       xfer_err;

  // Only the two isolation bits of ISOLATED are meaningful.
  assign iso_set = |prdata_i[1:0];
  logic unused_prdata;
  assign unused_prdata = ^prdata_i[DataWidth-1:2];

  // ---------------------------------------------------------------------------
  // Request decode. A request is raised once per access state; in_flight_q
  // masks it after the grant. The DEISO write is requested from the last
  // SETTLE cycle so its SETUP lands right after exactly WaitCycles idle cycles.
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    xfer_req   = 1'b0;
    xfer_wr    = 1'b1;
    xfer_addr  = AddrWidth'(CtrlRegOffset);
    xfer_wdata = '0;
    xfer_strb  = '1;
    case (state_q)
      ST_WR_UNRST: begin
        xfer_req   = !in_flight_q;
        xfer_wdata = DataWidth'(CMD_UNRST);
      end
      ST_WR_RST: begin
        xfer_req   = !in_flight_q;
        xfer_wdata = DataWidth'(CMD_RST);
      end
      ST_WR_CLKEN: begin
        xfer_req   = !in_flight_q;
        xfer_wdata = DataWidth'(CMD_CLKEN);
      end
      ST_SETTLE: begin
        xfer_req   = (settle_cnt_q == SettleLast);
        xfer_wdata = DataWidth'(CMD_DEISO);
      end
      ST_WR_DEISO: begin
        xfer_req   = !in_flight_q;
        xfer_wdata = DataWidth'(CMD_DEISO);
      end
      ST_POLL: begin
        xfer_req   = !in_flight_q;
        xfer_wr    = 1'b0;
        xfer_addr  = AddrWidth'(IsolatedRegOffset);
        xfer_strb  = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_flight_q <= 1'b0;
    end else if (xfer_gnt) begin
      in_flight_q <= 1'b1;
    end else if (xfer_done || xfer_err) begin
      in_flight_q <= 1'b0;
    end
  end

  // Settle counter runs only while in SETTLE and restarts on every entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      settle_cnt_q <= '0;
    end else if (state_q == ST_SETTLE) begin
      settle_cnt_q <= settle_cnt_q + 1'b1;
    end else begin
      settle_cnt_q <= '0;
    end
  end

`ifdef SERIAL_LINK_BRINGUP_TIMEOUT_EN
  localparam int               PollW     = $clog2(MaxPolls + 1);
  localparam logic [PollW-1:0] PollLast  = PollW'(MaxPolls - 1);
  logic [PollW-1:0]            poll_cnt_q;

  // Counts completed reads that still showed isolation; cleared before POLL.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      poll_cnt_q <= '0;
    end else if (state_q == ST_WR_DEISO) begin
      poll_cnt_q <= '0;
    end else if (state_q == ST_POLL && xfer_done && iso_set) begin
      poll_cnt_q <= poll_cnt_q + 1'b1;
    end
  end

  assign poll_limit_hit = (poll_cnt_q == PollLast);
`else
  // Without the timeout the controller polls until isolation clears.
  assign poll_limit_hit = 1'b0;
  logic [31:0] unused_max_polls;
  assign unused_max_polls = 32'(MaxPolls);
`endif

  // ---------------------------------------------------------------------------
  // Bring-up sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start_i) state_q <= ST_WR_UNRST;
        end
        ST_WR_UNRST: begin
          if (xfer_err)       state_q <= ST_ERROR;
          else if (xfer_done) state_q <= ST_WR_RST;
        end
        ST_WR_RST: begin
          if (xfer_err)       state_q <= ST_ERROR;
          else if (xfer_done) state_q <= ST_WR_CLKEN;
        end
        ST_WR_CLKEN: begin
          if (xfer_err)       state_q <= ST_ERROR;
          else if (xfer_done) state_q <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt_q == SettleLast) state_q <= ST_WR_DEISO;
        end
        ST_WR_DEISO: begin
          if (xfer_err)       state_q <= ST_ERROR;
          else if (xfer_done) state_q <= ST_POLL;
        end
        ST_POLL: begin
          if (xfer_err) begin
            state_q <= ST_ERROR;
          end else if (xfer_done) begin
            if (!iso_set)            state_q <= ST_DONE;
            else if (poll_limit_hit) state_q <= ST_ERROR;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o  = state_is_busy(state_q);
  assign done_o  = (state_q == ST_DONE);
  assign error_o = (state_q == ST_ERROR);

  serial_link_apb_mst #(
    .AddrWidth (AddrWidth),
    .DataWidth (DataWidth)
  ) u_apb (
    .clk     (clk_i),
    .rst     (rst_i),
    .req     (xfer_req),
    .wr      (xfer_wr),
    .addr    (xfer_addr),
    .wdata   (xfer_wdata),
    .strb    (xfer_strb),
    .gnt     (xfer_gnt),
    .done    (xfer_done),
    .err     (xfer_err),
    .paddr   (paddr_o),
    .psel    (psel_o),
    .penable (penable_o),
    .pwrite  (pwrite_o),
    .pwdata  (pwdata_o),
    .pstrb   (pstrb_o),
    .pready  (pready_i),
    .pslverr (pslverr_i)
  );

endmodule

// File: doc/serial_link_bringup_ctrl.md
SERIAL_LINK_BRINGUP_CTRL -- requirements
Module: serial_link_bringup_ctrl

Interface
REQ-001 SHALL have parameter AddrWidth, default 32, APB address width.
REQ-002 SHALL have parameter DataWidth, default 32, APB data width; pstrb width is DataWidth/8.
REQ-003 SHALL have parameter CtrlRegOffset, default 32'h0, CTRL register address.
REQ-004 SHALL have parameter IsolatedRegOffset, default 32'h4, ISOLATED register address.
REQ-005 SHALL have parameter WaitCycles, default 50, settle cycles after clock enable (>=1).
REQ-006 SHALL have parameter MaxPolls, default 1024, ISOLATED read limit (>=1).
REQ-007 SHALL have ports: clk_i in 1 clock; rst_i in 1 synchronous active-high reset.
REQ-008 SHALL have ports: start_i in 1 bring-up request pulse; busy_o out 1 sequence running; done_o out 1 link ready (sticky); error_o out 1 sequence failed (sticky).
REQ-009 SHALL have APB master ports: paddr_o out AddrWidth; psel_o out 1; penable_o out 1; pwrite_o out 1; pwdata_o out DataWidth; pstrb_o out DataWidth/8; prdata_i in DataWidth; pready_i in 1; pslverr_i in 1.

Function
REQ-010 SHALL implement states IDLE, WR_UNRST(32'h300), WR_RST(32'h302), WR_CLKEN(32'h303), SETTLE, WR_DEISO(32'h03), POLL, DONE, ERROR.
REQ-011 SHALL leave IDLE, DONE or ERROR on start_i=1 to WR_UNRST, clearing done_o/error_o; start_i is ignored in all other states.
REQ-012 SHALL perform each APB access as one SETUP cycle (psel_o=1, penable_o=0) followed by ACCESS cycles (psel_o=1, penable_o=1) until pready_i=1; paddr_o, pwrite_o, pwdata_o and pstrb_o stay stable over the transfer.
REQ-013 SHALL drive writes with pstrb_o all ones and paddr_o=CtrlRegOffset; POLL reads drive paddr_o=IsolatedRegOffset, pwrite_o=0, pstrb_o=0.
REQ-014 SHALL advance WR_UNRST->WR_RST->WR_CLKEN->SETTLE on each completed write (pready_i=1, pslverr_i=0).
REQ-015 SHALL keep psel_o=0 for exactly WaitCycles cycles in SETTLE, using a counter of width $clog2(WaitCycles+1), then go to WR_DEISO.
REQ-016 SHALL go from WR_DEISO to POLL on completion; in POLL, go to DONE when prdata_i[1:0]==2'b00 at completion, else issue another read after one idle cycle (psel_o=0).
REQ-017 SHALL go to ERROR on any completion with pslverr_i=1, from any access state.
REQ-018 SHALL assert busy_o in every state except IDLE, DONE and ERROR; done_o=1 only in DONE; error_o=1 only in ERROR.
REQ-019 SHALL drive all outputs from registers or state decode only, with no combinational path from APB inputs to outputs.

Reset
REQ-020 SHALL, on a clk_i edge with rst_i=1, enter IDLE, clear all counters, and drive psel_o=0, penable_o=0, pwrite_o=0, paddr_o=0, pwdata_o=0, pstrb_o=0, busy_o=0, done_o=0, error_o=0.
REQ-021 SHALL abort an in-flight APB transfer immediately on reset; no completion is awaited.

Configuration
REQ-022 SHALL, with SERIAL_LINK_BRINGUP_TIMEOUT_EN defined, count completed POLL reads and go to ERROR when MaxPolls reads complete without the isolation bits clearing.
REQ-023 SHALL, without SERIAL_LINK_BRINGUP_TIMEOUT_EN, omit the poll counter and poll indefinitely; MaxPolls is then unused.

Structure
REQ-024 SHALL take the state enum and the CTRL command constants (32'h300, 32'h302, 32'h303, 32'h03) from serial_link_pkg.
REQ-025 SHALL contain one sub-module, serial_link_apb_mst, an APB single-transfer engine with req/gnt/done/err signals, sequenced by the top-level FSM.

Verification
REQ-026 SHALL test the zero-wait slave with ISOLATED reading 0 on the first poll: start_i pulse -> writes 300,302,303; 50 idle cycles; write 03; one read; done_o=1.
REQ-027 SHALL test a slave with pready_i delayed 3 cycles: each transfer holds psel_o/penable_o high for 3 extra cycles with stable paddr_o and pwdata_o; the sequence still reaches done_o.
REQ-028 SHALL test ISOLATED returning 2'b11, 2'b10, then 2'b00: exactly 3 reads occur, with psel_o=0 for one cycle between them, then done_o=1.
REQ-029 SHALL test pslverr_i=1 on the 302 write: ERROR state, error_o=1, and no further APB accesses; a new start_i restarts from 300.
REQ-030 SHALL test, with the macro defined, MaxPolls=4 and ISOLATED stuck at 2'b01: error_o=1 after exactly 4 reads.
REQ-031 SHALL test rst_i=1 during SETTLE: all outputs are 0 on the next cycle, and start_i afterwards restarts the full sequence.
